// File: rtl/uart_pkg.sv
// Shared UART types: transmitter FSM states, parity modes, per-frame config, word-length helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Encoded as {sticky_parity, eps}
  typedef enum logic [1:0] {
    PAR_ODD   = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } parity_mode_t;

  typedef struct packed {
    logic [1:0] wls;
    logic       parity_en;
    logic       stop_bit;
  } tx_cfg_t;

  function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                      input parity_mode_t mode);
    logic [7:0] masked;
    logic       p;
    masked = data & (8'hFF >> (2'd3 - wls));
    case (mode)
      PAR_ODD:  p = ~^masked;
      PAR_EVEN: p = ^masked;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO, combinational read of the head entry; push ignored when full, pop ignored when empty.
// A pushed entry becomes visible to pop on the following cycle via the registered count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   baud_clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge baud_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter behind a holding FIFO; a frame starts the cycle after its byte is popped.
// wr_ready drops while the FIFO is full; queued bytes chain back-to-back with no idle bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        baud_clk,
  input  logic                        reset,
  input  logic [7:0]                  wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [1:0]                  wls,
  input  logic                        parity_en,
  input  logic                        eps,
  input  logic                        sticky_parity,
  input  logic                        stop_bit,
  input  logic                        tx_break,
  output logic                        txd_o,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_empty,
  output logic                        fifo_full
);
  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(3 * OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);

  tx_state_t     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d, tick_last_val;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  tx_cfg_t       cfg_q, cfg_d, cfg_in;
  logic          par_q, par_d;
  logic          brk_q;
  logic          tick_last, line, load;
  logic [7:0]    fifo_dat;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .baud_clk  (baud_clk),
    .reset     (reset),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (load),
    .pop_data  (fifo_dat),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign wr_ready = ~fifo_full;
  assign cfg_in   = '{wls: wls, parity_en: parity_en, stop_bit: stop_bit};

  // Only the stop bit may run longer than one bit time
  always_comb begin
    tick_last_val = BIT_LAST;
    if (state_q == STOP && cfg_q.stop_bit)
      tick_last_val = (cfg_q.wls == 2'b00) ? STOP15_LAST : STOP2_LAST;
  end
  assign tick_last = (tick_q == tick_last_val);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + TW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cfg_d   = cfg_q;
    par_d   = par_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        load   = ~fifo_empty;
      end
      START: if (tick_last) begin
        tick_d  = '0;
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (tick_last) begin
        tick_d  = '0;
        shreg_d = {1'b0, shreg_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if ({1'b0, bit_q} == wls_to_bits(cfg_q.wls) - 4'd1)
          state_d = cfg_q.parity_en ? PARITY : STOP;
      end
      PARITY: if (tick_last) begin
        tick_d  = '0;
        state_d = STOP;
      end
      STOP: if (tick_last) begin
        tick_d  = '0;
        state_d = IDLE;
        load    = ~fifo_empty;
      end
      default: state_d = IDLE;
    endcase
    // Config and parity are captured with the byte so mid-frame input changes are ignored
    if (load) begin
      state_d = START;
      tick_d  = '0;
      shreg_d = fifo_dat;
      cfg_d   = cfg_in;
      par_d   = parity_bit(fifo_dat, wls, parity_mode_t'({sticky_parity, eps}));
    end
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cfg_q   <= '0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      brk_q   <= tx_break;
    end
  end

  always_comb begin
    case (state_q)
      START:   line = 1'b0;
      DATA:    line = shreg_q[0];
      PARITY:  line = par_q;
      default: line = 1'b1;
    endcase
  end

  assign txd_o   = line & ~brk_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = (state_q == STOP) && tick_last;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: framing, parity modes, FIFO fill/backpressure, break and reset abort.
module tb_uart_tx_fifo;
  localparam int OS    = 16;
  localparam int DEPTH = 16;

  logic       baud_clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wls;
  logic       parity_en, eps, sticky_parity, stop_bit, tx_break;
  logic       txd_o, tx_busy, tx_done;
  logic [4:0] fifo_count;
  logic       fifo_empty, fifo_full;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_fifo #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .baud_clk      (baud_clk),
    .reset         (reset),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wls           (wls),
    .parity_en     (parity_en),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .stop_bit      (stop_bit),
    .tx_break      (tx_break),
    .txd_o         (txd_o),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .fifo_count    (fifo_count),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic pe, input logic ev,
                         input logic st, input logic sb);
    wls = w; parity_en = pe; eps = ev; sticky_parity = st; stop_bit = sb;
  endtask

  task automatic push(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, tx_busy, 0);
    check({tag, " txd"}, txd_o, 1);
    check({tag, " done"}, tx_done, 0);
    check({tag, " empty"}, fifo_empty, 1);
  endtask

  // Frame cycle c counts from the pop cycle (c=0); break window is in driven-cycle terms.
  task automatic run_frame(input string tag, input logic [7:0] d, input int nb, input logic pe,
                           input logic pb, input int stop_len, input int start_cyc,
                           input int brk_lo, input int brk_hi);
    int   total, k;
    logic e, in_brk;
    total = OS * (1 + nb + int'(pe)) + stop_len;
    for (int c = start_cyc + 1; c <= total; c++) begin
      in_brk   = (c - 1 >= brk_lo) && (c - 1 < brk_hi);
      tx_break = in_brk;
      tick();
      k = (c - 1) / OS;
      if (k == 0)                 e = 1'b0;
      else if (k <= nb)           e = d[k-1];
      else if (pe && k == nb + 1) e = pb;
      else                        e = 1'b1;
      if (in_brk) e = 1'b0;
      check($sformatf("%s txd c%0d", tag, c), txd_o, e);
      check($sformatf("%s done c%0d", tag, c), tx_done, c == total);
      check($sformatf("%s busy c%0d", tag, c), tx_busy, 1);
    end
    tx_break = 1'b0;
  endtask

  function automatic logic [7:0] dv(input int i);
    return 8'(i * 29 + 7);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lows, dones;
    reset = 1'b1; wr_data = '0; wr_valid = 1'b0; tx_break = 1'b0;
    set_cfg(2'd3, 0, 0, 0, 0);
    #2;
    check("rst txd", txd_o, 1);
    check("rst busy", tx_busy, 0);
    check("rst done", tx_done, 0);
    check("rst wr_ready", wr_ready, 1);
    check("rst empty", fifo_empty, 1);
    check("rst full", fifo_full, 0);
    check("rst count", fifo_count, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check_idle("post-rst");

    // 8N1 0xA5, second byte pushed in the same cycle as the first pop
    push(8'hA5);
    check("t1 count after push", fifo_count, 1);
    check("t1 still idle", tx_busy, 0);
    push(8'h3C);
    check("t1 count push+pop", fifo_count, 1);
    check("t1 start txd", txd_o, 0);
    run_frame("t1a", 8'hA5, 8, 0, 0, OS, 1, 0, 0);
    check("t1 count at chain", fifo_count, 1);
    run_frame("t1b", 8'h3C, 8, 0, 0, OS, 0, 0, 0);
    tick();
    check_idle("t1 end");

    // 5E1.5 0xFF; config scrambled mid-frame must not matter
    set_cfg(2'd0, 1, 1, 0, 1);
    push(8'hFF);
    tick();
    check("t2 start txd", txd_o, 0);
    set_cfg(2'd3, 0, 0, 1, 0);
    run_frame("t2", 8'hFF, 5, 1, 1, 24, 1, 0, 0);
    tick();
    check_idle("t2 end");

    // 7O2, bit 7 set but outside the word: parity over 4 ones -> 1
    set_cfg(2'd2, 1, 0, 0, 1);
    push(8'hB5);
    run_frame("t2b", 8'hB5, 7, 1, 1, 2 * OS, 0, 0, 0);
    tick();
    // stick parity forced 0, then forced 1
    set_cfg(2'd1, 1, 1, 1, 0);
    push(8'h3F);
    run_frame("t2c", 8'h3F, 6, 1, 0, OS, 0, 0, 0);
    tick();
    set_cfg(2'd1, 1, 0, 1, 0);
    push(8'h00);
    run_frame("t2d", 8'h00, 6, 1, 1, OS, 0, 0, 0);
    tick();
    check_idle("t2 end2");

    // Fill FIFO during a frame, 17th byte held until the first pop
    set_cfg(2'd3, 0, 0, 0, 0);
    push(8'h3C);
    tick();
    check("t3 count c1", fifo_count, 0);
    for (int i = 0; i < 16; i++) begin
      wr_data  = dv(i);
      wr_valid = 1'b1;
      tick();
      check($sformatf("t3 fill count %0d", i), fifo_count, i + 1);
    end
    check("t3 wr_ready full", wr_ready, 0);
    check("t3 full flag", fifo_full, 1);
    wr_data = dv(16);
    for (int c = 18; c <= 160; c++) begin
      tick();
      check($sformatf("t3 hold count c%0d", c), fifo_count, 16);
      check($sformatf("t3 x done c%0d", c), tx_done, c == 160);
    end
    tick();
    check("t3 count after pop", fifo_count, 15);
    check("t3 wr_ready after pop", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check("t3 17th accepted", fifo_count, 16);
    check("t3 full again", fifo_full, 1);
    for (int i = 0; i < 17; i++)
      run_frame($sformatf("t3 f%0d", i), dv(i), 8, 0, 0, OS, (i == 0) ? 2 : 0, 0, 0);
    tick();
    check_idle("t3 end");

    // Break for 40 cycles during DATA; frame end time unchanged
    push(8'hA5);
    run_frame("t4", 8'hA5, 8, 0, 0, OS, 0, 40, 80);
    tick();
    check_idle("t4 end");

    // Reset at DATA bit 3 with 4 queued bytes
    push(8'h52);
    tick();
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    check("t5 queued", fifo_count, 4);
    repeat (65) tick();
    check("t5 bit3 txd", txd_o, 0);
    check("t5 busy pre", tx_busy, 1);
    reset = 1'b1;
    #1;
    check("t5 async txd", txd_o, 1);
    check("t5 async count", fifo_count, 0);
    check("t5 async busy", tx_busy, 0);
    check("t5 async empty", fifo_empty, 1);
    check("t5 async wr_ready", wr_ready, 1);
    check("t5 async done", tx_done, 0);
    tick(); tick();
    reset = 1'b0;
    lows = 0; dones = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (txd_o !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    check("t5 no low after reset", lows, 0);
    check("t5 no done after reset", dones, 0);
    check("t5 count final", fifo_count, 0);
    check("t5 busy final", tx_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
